// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/op bus between the BIST engine and the ALU under test
interface alu_bist_if;
   logic [31:0] oprd1;
   logic [31:0] oprd2;
   logic [3:0]  ALU_Operation;
   logic [31:0] result;
   logic        zero;
   modport master (output oprd1, oprd2, ALU_Operation, input result, zero);
   modport slave  (input oprd1, oprd2, ALU_Operation, output result, zero);
endinterface

// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven self-test engine that drives an ALU and counts result/zero mismatches
module alu_bist #(
   parameter int unsigned NUM_VEC = 64,
   parameter logic [31:0] SEED    = 32'hACE1_2025
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       fail_count,
   output logic [15:0]       first_fail_idx,
   alu_bist_if.master        alu
);
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [15:0] LAST     = 16'(NUM_VEC - 1);
   state_t      r_state, w_next;
   logic [31:0] r_lfsr;
   logic [15:0] r_idx;
   logic [2:0]  r_opi;
   logic [15:0] r_fail_count, r_first_fail;
   logic        r_pass;
   logic [3:0]  w_op;
   logic [31:0] w_a, w_b, w_exp;
   logic        w_last, w_mismatch;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   // next-state and handshake outputs
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? DRIVE : IDLE;
         DRIVE:   w_next = CHECK;
         CHECK:   w_next = w_last ? DONE : DRIVE;
         default: w_next = IDLE;
      endcase
      busy = (r_state == DRIVE) || (r_state == CHECK);
      done = (r_state == DONE);
   end
   // op sequence indexed by i mod 7, tracked by r_opi to avoid a divider
   always_comb begin
      case (r_opi)
         3'd0:    w_op = 4'b0000;
         3'd1:    w_op = 4'b0001;
         3'd2:    w_op = 4'b0010;
         3'd3:    w_op = 4'b0110;
         3'd4:    w_op = 4'b0111;
         3'd5:    w_op = 4'b1100;
         default: w_op = 4'b1000;
      endcase
   end
   // vector operands, reference result and mismatch detection
   always_comb begin
      w_a = r_lfsr;
      w_b = (r_idx[2:0] == 3'b111) ? r_lfsr : ({r_lfsr[15:0], r_lfsr[31:16]} ^ 32'h5A5A_5A5A);
      case (w_op)
         4'b0000: w_exp = w_a & w_b;
         4'b0001: w_exp = w_a | w_b;
         4'b0010: w_exp = w_a + w_b;
         4'b0110: w_exp = w_a - w_b;
         4'b0111: w_exp = {31'd0, $signed(w_a) < $signed(w_b)};
         4'b1100: w_exp = ~(w_a | w_b);
         default: w_exp = w_a ^ w_b;
      endcase
      w_mismatch        = (alu.result != w_exp) || (alu.zero != (w_exp == 32'd0));
      w_last            = (r_idx == LAST);
      alu.oprd1         = busy ? w_a  : 32'd0;
      alu.oprd2         = busy ? w_b  : 32'd0;
      alu.ALU_Operation = busy ? w_op : 4'd0;
   end
   // run bookkeeping: LFSR, vector index, failure counters and verdict
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_lfsr       <= SEED_EFF;
         r_idx        <= 16'd0;
         r_opi        <= 3'd0;
         r_fail_count <= 16'd0;
         r_first_fail <= 16'hFFFF;
         r_pass       <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_lfsr       <= SEED_EFF;
         r_idx        <= 16'd0;
         r_opi        <= 3'd0;
         r_fail_count <= 16'd0;
         r_first_fail <= 16'hFFFF;
         r_pass       <= 1'b0;
      end else if (r_state == CHECK) begin
         r_lfsr <= (r_lfsr >> 1) ^ ({32{r_lfsr[0]}} & 32'h8020_0003);
         r_idx  <= r_idx + 16'd1;
         r_opi  <= (r_opi == 3'd6) ? 3'd0 : r_opi + 3'd1;
         if (w_mismatch && r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
         if (w_mismatch && r_first_fail == 16'hFFFF) r_first_fail <= r_idx;
         if (w_last) r_pass <= (r_fail_count == 16'd0) && !w_mismatch;
      end
   assign pass           = r_pass;
   assign fail_count     = r_fail_count;
   assign first_fail_idx = r_first_fail;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed, table-driven bench for the ALU BIST engine
module tb_alu_bist;
   logic clk = 1'b0;
   logic rst_n, start, start2;
   logic busy, done, pass, busy2, done2, pass2;
   logic [15:0] fc, ffi, fc2, ffi2;
   int alu_mode;
   int checks = 0;
   int failures = 0;
   alu_bist_if bus ();
   alu_bist_if bus2 ();
   localparam logic [31:0] SEED = 32'hACE1_2025;
   logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};
   logic [3:0]  tr_op [8];
   logic [31:0] tr_o1 [8];
   logic [31:0] tr_o2 [8];
   int stab_err;
   always #5 clk = ~clk;

   alu_bist dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
                 .fail_count(fc), .first_fail_idx(ffi), .alu(bus.master));
   alu_bist #(.NUM_VEC(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
                 .pass(pass2), .fail_count(fc2), .first_fail_idx(ffi2), .alu(bus2.master));

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         4'b1000: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
   endfunction

   function automatic logic [31:0] b_of(input int i, input logic [31:0] l);
      return (i % 8 == 7) ? l : ({l[15:0], l[31:16]} ^ 32'h5A5A_5A5A);
   endfunction

   // ALU under test: correct, result inverted, or zero flag stuck at 0
   always_comb begin
      logic [31:0] r;
      r = alu_f(bus.ALU_Operation, bus.oprd1, bus.oprd2);
      bus.result = (alu_mode == 1) ? ~r : r;
      bus.zero   = (alu_mode == 2) ? 1'b0 : (r == 32'd0);
      bus2.result = alu_f(bus2.ALU_Operation, bus2.oprd1, bus2.oprd2);
      bus2.zero   = (bus2.result == 32'd0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input int mode, output int bc, output int dc);
      int j;
      alu_mode = mode;
      bc = 0;
      dc = 0;
      stab_err = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (busy) begin
            bc++;
            j = (bc - 1) / 2;
            if (j < 8 && (bc - 1) % 2 == 0) begin
               tr_op[j] = bus.ALU_Operation;
               tr_o1[j] = bus.oprd1;
               tr_o2[j] = bus.oprd2;
            end else if (j < 8 && (tr_op[j] !== bus.ALU_Operation || tr_o1[j] !== bus.oprd1 || tr_o2[j] !== bus.oprd2))
               stab_err++;
         end
         if (done) begin
            dc++;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_trace(input string tag);
      logic [31:0] l;
      l = SEED;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("%s_op%0d", tag, j), 64'(tr_op[j]), 64'(ops[j % 7]));
         chk($sformatf("%s_oprd1_%0d", tag, j), 64'(tr_o1[j]), 64'(l));
         chk($sformatf("%s_oprd2_%0d", tag, j), 64'(tr_o2[j]), 64'(b_of(j, l)));
         l = lfsr_next(l);
      end
      chk({tag, "_i7_eq"}, 64'(tr_o2[7] == tr_o1[7]), 64'd1);
      chk({tag, "_stable"}, 64'(stab_err), 64'd0);
   endtask

   typedef struct {int mode; int fc; int ffi; int pass;} vec_t;

   initial begin
      vec_t tbl [3];
      int bc, dc, mfc, mffi, kd, b1, b2;
      logic [31:0] l, e;
      rst_n = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      alu_mode = 0;
      mfc = 0;
      mffi = 16'hFFFF;
      l = SEED;
      for (int i = 0; i < 64; i++) begin
         e = alu_f(ops[i % 7], l, b_of(i, l));
         if (e == 32'd0) begin
            mfc++;
            if (mffi == 16'hFFFF) mffi = i;
         end
         l = lfsr_next(l);
      end
      tbl[0] = '{0, 0, 16'hFFFF, 1};
      tbl[1] = '{1, 64, 0, 0};
      tbl[2] = '{2, mfc, mffi, (mfc == 0) ? 1 : 0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_fc", 64'(fc), 64'd0);
      chk("rst_ffi", 64'(ffi), 64'hFFFF);
      chk("rst_oprd1", 64'(bus.oprd1), 64'd0);
      for (int t = 0; t < 3; t++) begin
         run(tbl[t].mode, bc, dc);
         if (t == 0) check_trace("trace");
         chk($sformatf("run%0d_busy", t), 64'(bc), 64'd128);
         chk($sformatf("run%0d_done", t), 64'(dc), 64'd1);
         @(negedge clk);
         chk($sformatf("run%0d_done_pulse", t), 64'(done), 64'd0);
         chk($sformatf("run%0d_fc", t), 64'(fc), 64'(tbl[t].fc));
         chk($sformatf("run%0d_ffi", t), 64'(ffi), 64'(tbl[t].ffi));
         chk($sformatf("run%0d_pass", t), 64'(pass), 64'(tbl[t].pass));
         chk($sformatf("run%0d_idle_op", t), 64'(bus.ALU_Operation), 64'd0);
      end
      alu_mode = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre_rst_fc", 64'(fc), 64'd10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_pass", 64'(pass), 64'd0);
      chk("arst_fc", 64'(fc), 64'd0);
      chk("arst_ffi", 64'(ffi), 64'hFFFF);
      chk("arst_oprd1", 64'(bus.oprd1), 64'd0);
      chk("arst_oprd2", 64'(bus.oprd2), 64'd0);
      chk("arst_op", 64'(bus.ALU_Operation), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      dc = 0;
      repeat (10) @(negedge clk) if (done) dc++;
      chk("arst_no_done", 64'(dc), 64'd0);
      run(0, bc, dc);
      check_trace("retrace");
      chk("rerun_done", 64'(dc), 64'd1);
      @(negedge clk) start = 1'b1;
      bc = 0;
      kd = -1;
      b1 = -1;
      b2 = -1;
      for (int k = 0; k < 400; k++) begin
         if (busy && kd < 0) bc++;
         if (done && kd < 0) kd = k;
         if (kd >= 0 && k == kd + 1) b1 = busy;
         if (kd >= 0 && k == kd + 2) begin
            b2 = busy;
            break;
         end
         @(negedge clk);
      end
      chk("hold_busy", 64'(bc), 64'd128);
      chk("hold_after_done", 64'(b1), 64'd0);
      chk("hold_restart", 64'(b2), 64'd1);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      bc = 0;
      dc = 0;
      repeat (8) begin
         if (busy2) bc++;
         if (done2) dc++;
         @(negedge clk);
      end
      chk("nv1_busy", 64'(bc), 64'd2);
      chk("nv1_done", 64'(dc), 64'd1);
      chk("nv1_pass", 64'(pass2), 64'd1);
      chk("nv1_fc", 64'(fc2), 64'd0);
      chk("nv1_ffi", 64'(ffi2), 64'hFFFF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
